// File: rtl/ft_tx_framer.sv
// Frame builder feeding the FT245 write port: 4-byte header (sync word plus
// frame counter) followed by FRAME_BYTES payload bytes from a show-ahead FIFO.
module ft_tx_framer #(
    parameter int unsigned FRAME_BYTES = 614400,
    parameter logic [7:0]  SYNC0       = 8'hA5,
    parameter logic [7:0]  SYNC1       = 8'h5A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        frame_start,
    input  logic        ovr_clr,
    input  logic [7:0]  fifo_q,
    input  logic        fifo_empty,
    output logic        fifo_rdreq,
    input  logic        wr_ready,
    output logic        wr,
    output logic [7:0]  write_data,
    output logic [15:0] frame_cnt,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned    BCW  = $clog2(FRAME_BYTES + 1);
    localparam logic [BCW-1:0] LAST = BCW'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } state_t;

    state_t         state, state_nx;
    logic [1:0]     hdr_idx, hdr_idx_nx;
    logic [BCW-1:0] byte_cnt, byte_cnt_nx;
    logic [15:0]    frame_cnt_nx;
    logic           overrun_nx;
    logic           xfer;
    logic           last_xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hdr_idx   <= '0;
            byte_cnt  <= '0;
            frame_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            hdr_idx   <= hdr_idx_nx;
            byte_cnt  <= byte_cnt_nx;
            frame_cnt <= frame_cnt_nx;
            overrun   <= overrun_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        hdr_idx_nx   = hdr_idx;
        byte_cnt_nx  = byte_cnt;
        frame_cnt_nx = frame_cnt;
        wr           = 1'b0;
        fifo_rdreq   = 1'b0;
        write_data   = '0;
        busy         = 1'b0;
        xfer         = 1'b0;
        last_xfer    = 1'b0;

        case (state)
            IDLE: begin
                if (frame_start && en) begin
                    state_nx   = HEADER;
                    hdr_idx_nx = '0;
                end
            end
            HEADER: begin
                busy = 1'b1;
                wr   = wr_ready;
                case (hdr_idx)
                    2'd0:    write_data = SYNC0;
                    2'd1:    write_data = SYNC1;
                    2'd2:    write_data = frame_cnt[15:8];
                    default: write_data = frame_cnt[7:0];
                endcase
                xfer = wr && wr_ready;
                if (xfer) begin
                    hdr_idx_nx = hdr_idx + 2'd1;
                    if (hdr_idx == 2'd3) begin
                        state_nx    = PAYLOAD;
                        byte_cnt_nx = '0;
                    end
                end
            end
            PAYLOAD: begin
                busy       = 1'b1;
                write_data = fifo_q;
                wr         = wr_ready && !fifo_empty;
                fifo_rdreq = wr && wr_ready;
                xfer       = wr && wr_ready;
                if (xfer) begin
                    byte_cnt_nx = byte_cnt + 1'b1;
                    if (byte_cnt == LAST) begin
                        last_xfer    = 1'b1;
                        frame_cnt_nx = frame_cnt + 16'd1;
                        // A start pulse landing on the final byte chains straight into the next header.
                        if (frame_start && en) begin
                            state_nx   = HEADER;
                            hdr_idx_nx = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        if (frame_start && busy && !last_xfer)
            overrun_nx = 1'b1;
        else if (ovr_clr)
            overrun_nx = 1'b0;
        else
            overrun_nx = overrun;
    end

endmodule

// File: doc/ft_tx_framer.md
Name: ft_tx_framer

Overview:
Upstream feeder for the FT245 synchronous-FIFO interface block. It pulls captured pixel bytes from a show-ahead pixel FIFO and presents them on the FT interface's write port (wr / write_data, gated by wr_ready). Each frame is prefixed with a 4-byte header: sync word plus a 16-bit frame counter. This lets the host resynchronise on frame boundaries.

Parameters:
FRAME_BYTES, 614400, payload bytes per frame (default 640x480x2); must be >= 1.
SYNC0, 8'hA5, first header byte.
SYNC1, 8'h5A, second header byte.

Ports:
clk  input  1  system clock (FT interface clock domain)
rst_n  input  1  asynchronous reset, active low
en  input  1  permits starting new frames; level
frame_start  input  1  single-cycle pulse from capture side, synchronous to clk
ovr_clr  input  1  clears overrun flag
fifo_q  input  8  show-ahead pixel FIFO head byte
fifo_empty  input  1  pixel FIFO empty
fifo_rdreq  output  1  pops the FIFO head byte
wr_ready  input  1  FT interface can accept a byte this cycle
wr  output  1  write request to FT interface (drives WR_n and the bus)
write_data  output  8  byte to FT interface
frame_cnt  output  16  frames fully sent since reset
busy  output  1  high in HEADER or PAYLOAD
overrun  output  1  sticky: frame_start arrived while busy

Behaviour:
- Reset (async, rst_n low):
  - state IDLE; hdr_idx 0; byte_cnt 0; frame_cnt 0; overrun 0.
  - Combinational outputs resolve to wr 0, fifo_rdreq 0, write_data 8'h00, busy 0.
- Transfer definition: a byte moves when wr & wr_ready in the same cycle. wr is never asserted while wr_ready is low. write_data must not change until the byte has transferred.
- wr, fifo_rdreq and write_data are combinational from state, counters, wr_ready and fifo_empty. There is no pipeline latency: the header byte is presented the cycle after the state enters HEADER.
- States:
  - IDLE:
    - wr = 0, write_data = 0.
    - If frame_start & en: go to HEADER, hdr_idx <= 0.
  - HEADER:
    - write_data by hdr_idx: 0 = SYNC0, 1 = SYNC1, 2 = frame_cnt[15:8], 3 = frame_cnt[7:0].
    - wr = wr_ready; fifo_rdreq = 0.
    - On transfer: hdr_idx++. On the transfer with hdr_idx == 3: go to PAYLOAD, byte_cnt <= 0.
  - PAYLOAD:
    - write_data = fifo_q; wr = wr_ready & ~fifo_empty; fifo_rdreq = wr & wr_ready.
    - On transfer: byte_cnt++.
    - On the transfer with byte_cnt == FRAME_BYTES-1: frame_cnt++ (wraps 16'hFFFF -> 0), then go to IDLE.
- byte_cnt width: $clog2(FRAME_BYTES+1). hdr_idx: 2 bits.
- Stalls:
  - wr_ready low (TXE_n high or FT interface busy reading): hold all state, no transfer.
  - fifo_empty in PAYLOAD: hold, no transfer, no pop.
- en:
  - Sampled only in IDLE.
  - Deasserting en mid-frame does not abort; the current frame completes.
- frame_start while busy:
  - Ignored; overrun <= 1.
  - Exception: frame_start in the same cycle as the final payload transfer is accepted. State goes directly to HEADER with no IDLE cycle, no overrun, and the header carries the already-incremented frame_cnt.
- overrun:
  - Sticky; cleared by ovr_clr.
  - ovr_clr and a new overrun event in the same cycle: overrun = 1 (set wins).
- The header frame_cnt value equals the number of frames completed before this frame (first frame after reset sends 0x0000).
- No byte is ever duplicated or dropped: the FIFO pops exactly FRAME_BYTES times per frame.

Test Plan:
1. FRAME_BYTES=4, wr_ready=1, FIFO preloaded 11,22,33,44, en=1, pulse frame_start. Required: bytes A5,5A,00,00,11,22,33,44 on 8 consecutive cycles; 4 fifo_rdreq pulses; frame_cnt=1; busy drops after the last byte.
2. Same setup with wr_ready low for 3 cycles during header byte 2 and during payload byte 33. Required: write_data held and wr=0 during each stall; byte sequence unchanged; no extra pops.
3. fifo_empty asserted for 5 cycles mid-payload. Required: wr=0 and fifo_rdreq=0 throughout; stream resumes with the correct next byte; byte_cnt intact.
4. Second frame_start pulsed mid-payload. Required: overrun=1 and stays set; frame completes normally; ovr_clr clears it. Then frame_start coincident with the final payload transfer: HEADER entered next cycle, header carries 00,01, overrun stays 0.
5. Preset frame_cnt by sending 65535 frames (FRAME_BYTES=1). Required: header bytes FF,FF on the next frame, then frame_cnt wraps to 0.
6. rst_n pulsed low mid-payload. Required: wr=0, fifo_rdreq=0, frame_cnt=0, busy=0, overrun=0 immediately; the next frame_start sends header 00,00.
